// File: rtl/jtag_scan_master.sv
// jtag_scan_master
//   JTAG scan master. It accepts DR-scan, IR-scan and TAP-reset commands,
//   drives registered tms/tdi to the target, captures tdo during shift
//   cycles, and keeps a mirror of the target TAP controller state.
//
//   Ports
//     tck        sole clock; all logic runs on its rising edge
//     trst       synchronous active-high reset
//     cmd_valid  command request; accepted on an edge where cmd_ready is also high
//     cmd_ready  high only when idle in Run-Test/Idle with tms low
//     cmd_op     00 DR scan, 01 IR scan, 10 TAP reset, 11 reserved (error)
//     cmd_len    scan length in bits, legal range 1..32
//     cmd_data   TDI bits, LSB shifted first
//     cmd_idle   extra Run-Test/Idle cycles after a scan (optional, see below)
//     tms, tdi   registered TAP pins
//     tdo        TAP data from the target
//     rsp_valid  one-cycle response pulse
//     rsp_data   captured TDO, LSB first; held until the next response
//     rsp_err    pulses with rsp_valid for an illegal command
//     tap_state  mirrored TAP state, IEEE 1149.1 encoding (TLR=F, RTI=C)
//
//   Optional feature: define JTAG_SCAN_MASTER_RTI_WAIT_EN to add the cmd_idle
//   input. It is latched at acceptance, and a scan then holds tms=0 in RTI for
//   cmd_idle extra cycles before responding.
module jtag_scan_master (
  input  logic        tck,
  input  logic        trst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_len,
  input  logic [31:0] cmd_data,
`ifdef JTAG_SCAN_MASTER_RTI_WAIT_EN
  input  logic [7:0]  cmd_idle,
`endif
  output logic        tms,
  output logic        tdi,
  input  logic        tdo,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [3:0]  tap_state
);

  typedef enum logic [3:0] {
    TAP_EXIT2_DR = 4'h0, TAP_EXIT1_DR = 4'h1, TAP_SHIFT_DR = 4'h2, TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4, TAP_UPD_DR   = 4'h5, TAP_CAP_DR   = 4'h6, TAP_SEL_DR   = 4'h7,
    TAP_EXIT2_IR = 4'h8, TAP_EXIT1_IR = 4'h9, TAP_SHIFT_IR = 4'hA, TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC, TAP_UPD_IR   = 4'hD, TAP_CAP_IR   = 4'hE, TAP_TLR      = 4'hF
  } tap_e;

  typedef enum logic [2:0] {
    ST_RST, ST_IDLE, ST_TLR, ST_HEAD, ST_SHIFT, ST_TAIL
  } st_e;

  st_e         st;
  tap_e        tap, tap_nxt;
  logic [8:0]  cnt;
  logic [5:0]  len_m1;
  logic        ir;
  logic        quiet;
  logic [31:0] sh;
  logic [31:0] cap;
  logic [8:0]  tail_end;
  logic        accept;
  logic        cmd_bad;

`ifdef JTAG_SCAN_MASTER_RTI_WAIT_EN
  logic [7:0]  idle_q;
  assign tail_end = 9'd2 + {1'b0, idle_q};
`else
  assign tail_end = 9'd2;
`endif

  assign tap_state = tap;
  assign cmd_ready = (st == ST_IDLE) && (tap == TAP_RTI) && !tms;
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_bad   = (cmd_op == 2'b11) || (cmd_len == 6'd0) || (cmd_len > 6'd32);

  always_comb begin
    tap_nxt = tap;
    case (tap)
      TAP_TLR:      tap_nxt = tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      tap_nxt = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   tap_nxt = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   tap_nxt = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: tap_nxt = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: tap_nxt = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: tap_nxt = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: tap_nxt = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   tap_nxt = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   tap_nxt = tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   tap_nxt = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: tap_nxt = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: tap_nxt = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: tap_nxt = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: tap_nxt = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   tap_nxt = tms ? TAP_SEL_DR   : TAP_RTI;
      default:      tap_nxt = TAP_TLR;
    endcase
  end

  always_ff @(posedge tck) begin
    if (trst) begin
      st        <= ST_RST;
      tap       <= TAP_TLR;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      cnt       <= '0;
      len_m1    <= '0;
      ir        <= 1'b0;
      quiet     <= 1'b1;
      sh        <= '0;
      cap       <= '0;
`ifdef JTAG_SCAN_MASTER_RTI_WAIT_EN
      idle_q    <= '0;
`endif
    end else begin
      tap       <= tap_nxt;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (st)
        // The post-reset walk runs as a silent TAP-reset op that finishes one
        // cycle earlier, so cmd_ready rises as soon as RTI is reached.
        ST_RST: begin
          st    <= ST_TLR;
          tms   <= 1'b1;
          cnt   <= '0;
          quiet <= 1'b1;
        end
        ST_IDLE: begin
          if (accept) begin
            cap    <= '0;
            sh     <= cmd_data;
            len_m1 <= cmd_len - 6'd1;
            ir     <= (cmd_op == 2'b01);
            quiet  <= 1'b0;
            cnt    <= '0;
`ifdef JTAG_SCAN_MASTER_RTI_WAIT_EN
            idle_q <= cmd_idle;
`endif
            if (cmd_bad) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end else if (cmd_op == 2'b10) begin
              st  <= ST_TLR;
              tms <= 1'b1;
            end else begin
              st  <= ST_HEAD;
              tms <= 1'b1;
            end
          end
        end
        ST_TLR: begin
          cnt <= cnt + 9'd1;
          if (cnt == 9'd4) tms <= 1'b0;
          if (cnt == (quiet ? 9'd5 : 9'd6)) begin
            st <= ST_IDLE;
            if (!quiet) begin
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
            end
          end
        end
        // Walk RTI -> SHIFT_xR: DR uses tms 1,0,0 and IR uses 1,1,0,0.
        ST_HEAD: begin
          if (cnt == (ir ? 9'd3 : 9'd2)) begin
            st  <= ST_SHIFT;
            cnt <= '0;
            tdi <= sh[0];
            sh  <= sh >> 1;
            tms <= (len_m1 == 6'd0);
          end else begin
            cnt <= cnt + 9'd1;
            tms <= ir && (cnt == 9'd0);
          end
        end
        // cnt holds the shift index of the period that ends at this edge.
        ST_SHIFT: begin
          cap[cnt[4:0]] <= tdo;
          if (cnt[5:0] == len_m1) begin
            st  <= ST_TAIL;
            cnt <= '0;
            tdi <= 1'b0;
            tms <= 1'b1;
          end else begin
            cnt <= cnt + 9'd1;
            tdi <= sh[0];
            sh  <= sh >> 1;
            tms <= ((cnt[5:0] + 6'd1) == len_m1);
          end
        end
        // EXIT1 -> UPDATE -> RTI, then one settle cycle (plus any extra idle).
        ST_TAIL: begin
          tms <= 1'b0;
          cnt <= cnt + 9'd1;
          if (cnt == tail_end) begin
            st        <= ST_IDLE;
            rsp_valid <= 1'b1;
            rsp_data  <= cap;
          end
        end
        default: st <= ST_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_scan_master.sv
module tb_jtag_scan_master;

  logic        tck = 1'b0;
  logic        trst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        tms;
  logic        tdi;
  logic        tdo;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  tap_state;

  logic        tdo_drv;
  logic        loop_en;
  int          checks = 0;
  int          errors = 0;

  logic [3:0]  tlr_tap [8] = '{4'hC, 4'h7, 4'h4, 4'hF, 4'hF, 4'hF, 4'hC, 4'hC};

  assign tdo = loop_en ? tdi : tdo_drv;

  always #5 tck = ~tck;

  jtag_scan_master dut (
    .tck       (tck),
    .trst      (trst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
`ifdef JTAG_SCAN_MASTER_RTI_WAIT_EN
    .cmd_idle  (8'd0),
`endif
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .tap_state (tap_state)
  );

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Hold trst for two edges, check reset outputs, then follow the
  // autonomous 1,1,1,1,1,0 walk to RTI with cmd_ready in the 7th cycle.
  task automatic do_reset(input string tag);
    trst = 1'b1;
    cmd_valid = 1'b0;
    tick();
    tick();
    chk1 ({tag, ":rst_tms"},   tms, 1'b1);
    chk1 ({tag, ":rst_tdi"},   tdi, 1'b0);
    chk1 ({tag, ":rst_ready"}, cmd_ready, 1'b0);
    chk1 ({tag, ":rst_rv"},    rsp_valid, 1'b0);
    chk1 ({tag, ":rst_err"},   rsp_err, 1'b0);
    chk32({tag, ":rst_data"},  rsp_data, 32'h0);
    chk4 ({tag, ":rst_tap"},   tap_state, 4'hF);
    trst = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      tick();
      chk1({tag, $sformatf(":seq%0d_tms", n)},   tms, (n <= 5));
      chk4({tag, $sformatf(":seq%0d_tap", n)},   tap_state, (n <= 6) ? 4'hF : 4'hC);
      chk1({tag, $sformatf(":seq%0d_ready", n)}, cmd_ready, (n == 7));
      chk1({tag, $sformatf(":seq%0d_rv", n)},    rsp_valid, 1'b0);
    end
  endtask

  // Issue one scan and check tms/tdi/tap_state every cycle up to the response.
  task automatic scan(input logic is_ir, input int len, input logic [31:0] data,
                      input logic [31:0] pat, input logic loop,
                      input logic [31:0] exp_rsp, input string tag);
    int   h;
    int   last;
    logic shift;
    logic e_tms;
    logic e_tdi;
    logic [3:0] e_tap;
    h    = is_ir ? 4 : 3;
    last = h + len + 3;
    chk1({tag, ":ready_pre"}, cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = is_ir ? 2'b01 : 2'b00;
    cmd_len   = 6'(len);
    cmd_data  = data;
    loop_en   = loop;
    tdo_drv   = 1'b0;
    tick();
    // Changing the command inputs after acceptance must not matter.
    cmd_valid = 1'b0;
    cmd_op    = 2'b10;
    cmd_len   = 6'd0;
    cmd_data  = ~data;
    for (int p = 0; p <= last; p++) begin
      shift = (p >= h) && (p < h + len);
      e_tms = (p == 0) || (is_ir && p == 1) || (p == h + len - 1) || (p == h + len);
      e_tdi = shift ? data[p - h] : 1'b0;
      if (p == 0)                e_tap = 4'hC;
      else if (p == 1)           e_tap = 4'h7;
      else if (p < h)            e_tap = !is_ir ? 4'h6 : ((p == 2) ? 4'h4 : 4'hE);
      else if (shift)            e_tap = is_ir ? 4'hA : 4'h2;
      else if (p == h + len)     e_tap = is_ir ? 4'h9 : 4'h1;
      else if (p == h + len + 1) e_tap = is_ir ? 4'hD : 4'h5;
      else                       e_tap = 4'hC;
      chk1({tag, $sformatf(":c%0d_tms", p)},   tms, e_tms);
      chk1({tag, $sformatf(":c%0d_tdi", p)},   tdi, e_tdi);
      chk4({tag, $sformatf(":c%0d_tap", p)},   tap_state, e_tap);
      chk1({tag, $sformatf(":c%0d_rv", p)},    rsp_valid, (p == last));
      chk1({tag, $sformatf(":c%0d_ready", p)}, cmd_ready, (p == last));
      if (p == last) begin
        chk32({tag, ":rsp_data"}, rsp_data, exp_rsp);
        chk1 ({tag, ":rsp_err"},  rsp_err, 1'b0);
      end else begin
        tdo_drv = shift ? pat[p - h] : 1'b0;
        tick();
      end
    end
    tick();
    chk1 ({tag, ":rv_drop"},   rsp_valid, 1'b0);
    chk32({tag, ":data_hold"}, rsp_data, exp_rsp);
    chk1 ({tag, ":ready_post"}, cmd_ready, 1'b1);
    loop_en = 1'b0;
  endtask

  // Illegal command: immediate error response, no TAP activity.
  task automatic bad(input logic [5:0] len, input logic [1:0] op, input string tag);
    chk1({tag, ":ready_pre"}, cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = 32'hDEADBEEF;
    tick();
    cmd_valid = 1'b0;
    chk1 ({tag, ":rv"},   rsp_valid, 1'b1);
    chk1 ({tag, ":err"},  rsp_err, 1'b1);
    chk32({tag, ":data"}, rsp_data, 32'h0);
    chk1 ({tag, ":tms"},  tms, 1'b0);
    chk4 ({tag, ":tap"},  tap_state, 4'hC);
    tick();
    chk1({tag, ":rv_drop"},  rsp_valid, 1'b0);
    chk1({tag, ":err_drop"}, rsp_err, 1'b0);
    chk1({tag, ":tms2"},     tms, 1'b0);
    chk4({tag, ":tap2"},     tap_state, 4'hC);
    chk1({tag, ":ready2"},   cmd_ready, 1'b1);
  endtask

  initial begin
    trst      = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = 6'd0;
    cmd_data  = 32'h0;
    tdo_drv   = 1'b0;
    loop_en   = 1'b0;

    do_reset("rst");

    scan(1'b0, 8,  32'h000000A5, 32'h0000003C, 1'b0, 32'h0000003C, "dr8");
    scan(1'b1, 4,  32'h00000009, 32'h00000005, 1'b0, 32'h00000005, "ir4");
    scan(1'b0, 1,  32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000001, "dr1");
    scan(1'b0, 32, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'hFFFFFFFF, "dr32");
    scan(1'b1, 7,  32'h00000055, 32'h00000000, 1'b1, 32'h00000055, "ir7");

    bad(6'd0,  2'b00, "len0");
    bad(6'd5,  2'b11, "op3");
    bad(6'd33, 2'b01, "len33");

    scan(1'b0, 5,  32'h00000013, 32'hFFFFFFFF, 1'b0, 32'h0000001F, "dr5");

    // TAP reset op: tms 1 x5 then 0, response 7 cycles after acceptance.
    chk1("tlr:ready_pre", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_len   = 6'd8;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    for (int p = 0; p <= 7; p++) begin
      chk1($sformatf("tlr:c%0d_tms", p),   tms, (p <= 4));
      chk4($sformatf("tlr:c%0d_tap", p),   tap_state, tlr_tap[p]);
      chk1($sformatf("tlr:c%0d_rv", p),    rsp_valid, (p == 7));
      chk1($sformatf("tlr:c%0d_ready", p), cmd_ready, (p == 7));
      if (p == 7) begin
        chk32("tlr:rsp_data", rsp_data, 32'h0);
        chk1 ("tlr:rsp_err",  rsp_err, 1'b0);
      end else begin
        tick();
      end
    end
    tick();

    // Abort a len=16 DR scan part-way through shifting.
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_len   = 6'd16;
    cmd_data  = 32'h00001234;
    tick();
    cmd_valid = 1'b0;
    for (int p = 0; p < 10; p++) begin
      chk1($sformatf("abort:c%0d_rv", p), rsp_valid, 1'b0);
      if (p < 9) tick();
    end
    chk4("abort:in_shift", tap_state, 4'h2);
    do_reset("abort");

    scan(1'b0, 16, 32'h00001234, 32'h0000BEEF, 1'b0, 32'h0000BEEF, "after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
